// File: rtl/reg_read_issue_scoreboard.sv
// Read/issue stage between decode and execute: tracks in-flight destination writes per register,
// stalls ops on read-after-write hazards and drives the register file read/write ports.
module reg_read_issue_scoreboard #(
    parameter int NUM_REGS    = 16,
    parameter int SEL_W       = 4,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_W-1:0]    in_sel_ra,
    input  logic [SEL_W-1:0]    in_sel_rb,
    input  logic [SEL_W-1:0]    in_sel_rc,
    input  logic                in_use_ra,
    input  logic                in_use_rb,
    input  logic                in_use_rc,
    input  logic                in_dest_en,
    input  logic [SEL_W-1:0]    in_dest_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data_ra,
    output logic [DATA_W-1:0]   out_data_rb,
    output logic [DATA_W-1:0]   out_data_rc,
    output logic                out_dest_en,
    output logic [SEL_W-1:0]    out_dest_sel,
    input  logic                wb_en,
    input  logic [SEL_W-1:0]    wb_sel,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [SEL_W-1:0]    rf_read_sel_ra,
    output logic [SEL_W-1:0]    rf_read_sel_rb,
    output logic [SEL_W-1:0]    rf_read_sel_rc,
    input  logic [DATA_W-1:0]   rf_read_data_ra,
    input  logic [DATA_W-1:0]   rf_read_data_rb,
    input  logic [DATA_W-1:0]   rf_read_data_rc,
    output logic                rf_write_en,
    output logic [SEL_W-1:0]    rf_write_sel,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err_underflow
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high; a producer
    // holds valid and payload stable until that cycle and never derives valid from ready.
    logic [CNT_W-1:0]    pend_cnt [NUM_REGS];
    logic [SEL_W-1:0]    hold_sel [3];
    logic [SEL_W-1:0]    src_sel  [3];
    logic [2:0]          src_use;
    logic [2:0]          src_haz;
    logic                dest_full;
    logic                stall_out;
    logic                accept;
    logic                underflow;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    assign src_sel[0] = in_sel_ra;
    assign src_sel[1] = in_sel_rb;
    assign src_sel[2] = in_sel_rc;
    assign src_use    = {in_use_rc, in_use_rb, in_use_ra};

    // A source whose only pending write lands this cycle is read through the register file bypass.
    always_comb begin
        src_haz = '0;
        for (int i = 0; i < 3; i++) begin
            src_haz[i] = src_use[i] && (src_sel[i] != '0) && (pend_cnt[src_sel[i]] != '0)
                         && !((pend_cnt[src_sel[i]] == CNT_ONE) && wb_en && (wb_sel == src_sel[i]));
        end
    end

    assign dest_full = in_dest_en && (in_dest_sel != '0) && (pend_cnt[in_dest_sel] == CNT_MAX)
                       && !(wb_en && (wb_sel == in_dest_sel));
    assign stall_out = out_valid && !out_ready;
    assign in_ready  = !stall_out && (src_haz == '0) && !dest_full;
    assign accept    = in_valid && in_ready;
    assign underflow = wb_en && (wb_sel != '0) && (pend_cnt[wb_sel] == '0);

    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_vec[r]  = (r != 0) && accept && in_dest_en && (in_dest_sel == SEL_W'(r));
            dec_vec[r]  = (r != 0) && wb_en && (wb_sel == SEL_W'(r)) && (pend_cnt[r] != '0);
            busy_vec[r] = (pend_cnt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    pend_cnt[r] <= pend_cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    pend_cnt[r] <= pend_cnt[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_dest_en   <= 1'b0;
            out_dest_sel  <= '0;
            err_underflow <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                hold_sel[i] <= '0;
            end
        end else begin
            if (accept) begin
                out_valid    <= 1'b1;
                out_dest_en  <= in_dest_en;
                out_dest_sel <= in_dest_sel;
                for (int i = 0; i < 3; i++) begin
                    hold_sel[i] <= src_sel[i];
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // While the output is stalled the register file keeps re-reading the held sources, which keeps
    // the operand data stable: no writer can be in flight for a source that passed the hazard check.
    assign rf_read_sel_ra = stall_out ? hold_sel[0] : in_sel_ra;
    assign rf_read_sel_rb = stall_out ? hold_sel[1] : in_sel_rb;
    assign rf_read_sel_rc = stall_out ? hold_sel[2] : in_sel_rc;

    assign out_data_ra = rf_read_data_ra;
    assign out_data_rb = rf_read_data_rb;
    assign out_data_rc = rf_read_data_rc;

    assign rf_write_en   = wb_en;
    assign rf_write_sel  = wb_sel;
    assign rf_write_data = wb_data;

endmodule
